// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared width default and controller state encoding for the RSA decrypt block
package rsa_pkg;

    localparam int RSA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } rsa_state_t;

endpackage

// File: rtl/rsa_modmul_seq.sv
// rtl/rsa_modmul_seq.sv - sequential a*b mod n by MSB-first shift-add, done pulse WIDTH+1 cycles after start
module rsa_modmul_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_r, b_r, n_r, p_r;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [WIDTH+1:0] n_ext, sum, t1, t2;

    // p < n keeps 2p + b below 3n, so two conditional subtractions always suffice
    always_comb begin
        n_ext = {2'b00, n_r};
        sum   = {1'b0, p_r, 1'b0} + {2'b00, (a_r[WIDTH-1] ? b_r : {WIDTH{1'b0}})};
        t1    = (sum >= n_ext) ? (sum - n_ext) : sum;
        t2    = (t1 >= n_ext) ? (t1 - n_ext) : t1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            n_r  <= '0;
            p_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                b_r  <= b;
                n_r  <= n;
                p_r  <= '0;
                cnt  <= CW'(WIDTH);
                busy <= 1'b1;
            end else if (busy) begin
                p_r <= t2[WIDTH-1:0];
                a_r <= {a_r[WIDTH-2:0], 1'b0};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = p_r;

endmodule

// File: rtl/rsa_decrypt.sv
// rtl/rsa_decrypt.sv - RSA m = c^d mod n by left-to-right square-and-multiply; RSA_DEC_RANGE_CHK_EN adds c>=n / n<2 error flagging
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cipht,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n_key,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] plaint,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_state_t       state, state_nx;
    logic [WIDTH-1:0] c_r, d_r, n_r, acc;
    logic [IW-1:0]    bit_idx, msb_idx;
    logic             issued, mm_start, mm_done, bit_dec, last_bit, range_err;
    logic [WIDTH-1:0] mm_b, mm_p;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d_r[i]) msb_idx = IW'(i);
        end
    end

`ifdef RSA_DEC_RANGE_CHK_EN
    assign range_err = (c_r >= n_r) || (n_r < WIDTH'(2));
`else
    assign range_err = 1'b0;
`endif

    assign last_bit = (bit_idx == '0);
    assign mm_b     = (state == MUL) ? c_r : acc;

    always_comb begin
        state_nx = state;
        mm_start = 1'b0;
        bit_dec  = 1'b0;
        case (state)
            IDLE: if (in_valid) state_nx = LOAD;
            LOAD: state_nx = (range_err || d_r == '0) ? DONE : SQR;
            SQR: begin
                if (!issued) begin
                    mm_start = 1'b1;
                end else if (mm_done) begin
                    if (d_r[bit_idx]) begin
                        state_nx = MUL;
                    end else if (last_bit) begin
                        state_nx = DONE;
                    end else begin
                        bit_dec = 1'b1;
                    end
                end
            end
            MUL: begin
                if (!issued) begin
                    mm_start = 1'b1;
                end else if (mm_done) begin
                    state_nx = last_bit ? DONE : SQR;
                    bit_dec  = !last_bit;
                end
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            c_r     <= '0;
            d_r     <= '0;
            n_r     <= '0;
            acc     <= '0;
            bit_idx <= '0;
            issued  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_r <= cipht;
                        d_r <= d_key;
                        n_r <= n_key;
                    end
                end
                LOAD: begin
                    // d==0 yields 1 mod n, which is 0 only for the degenerate n<=1
                    if (range_err) acc <= '0;
                    else if (d_r == '0) acc <= (n_r > WIDTH'(1)) ? WIDTH'(1) : '0;
                    else acc <= WIDTH'(1);
                    bit_idx <= msb_idx;
                    issued  <= 1'b0;
                end
                SQR, MUL: begin
                    if (mm_start) begin
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        issued <= 1'b0;
                        acc    <= mm_p;
                    end
                    if (bit_dec) bit_idx <= bit_idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    rsa_modmul_seq #(.WIDTH(WIDTH)) u_mm (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (acc),
        .b     (mm_b),
        .n     (n_r),
        .done  (mm_done),
        .p     (mm_p)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign plaint    = out_valid ? acc : '0;

`ifdef RSA_DEC_RANGE_CHK_EN
    logic err_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_r <= 1'b0;
        else if (state == LOAD) err_r <= range_err;
    end

    assign err = out_valid && err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_decrypt.sv
// tb/tb_rsa_decrypt.sv - randomized self-checking bench for rsa_decrypt against a modular-exponent reference
module tb_rsa_decrypt;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] cipht = '0, d_key = '0, n_key = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, err;
    logic [W-1:0] plaint;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] got_p;
    logic         got_err;
    int           lat;
    bit           ok;

    always #5 clk = ~clk;

    rsa_decrypt #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cipht     (cipht),
        .d_key     (d_key),
        .n_key     (n_key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plaint    (plaint),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_modexp(input longint unsigned c, input longint unsigned d,
                                                   input longint unsigned n);
        longint unsigned r, base, e;
        r    = 1 % n;
        base = c % n;
        e    = d;
        while (e != 0) begin
            if (e[0]) r = (r * base) % n;
            base = (base * base) % n;
            e    = e >> 1;
        end
        return r;
    endfunction

    task automatic start_job(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n);
        int t;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        cipht    = c;
        d_key    = d;
        n_key    = n;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cipht    = $urandom;
        d_key    = $urandom;
        n_key    = $urandom;
    endtask

    task automatic wait_result();
        lat = 1;
        while (!out_valid && lat < 6000) begin
            @(negedge clk);
            lat++;
        end
        ok      = out_valid;
        got_p   = plaint;
        got_err = err;
        check("result_timeout", ok, 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1'b1);
        check("out_valid_after_hs", out_valid, 1'b0);
        check("plaint_idle_zero", plaint, '0);
    endtask

    task automatic run_job(input string tag, input logic [W-1:0] c, input logic [W-1:0] d,
                           input logic [W-1:0] n, input logic [W-1:0] exp_p, input logic exp_err);
        start_job(c, d, n);
        wait_result();
        check({tag, "_plaint"}, got_p, exp_p);
        check({tag, "_err"}, got_err, exp_err);
        handshake();
    endtask

    // each modular multiply: done pulse exactly W+1 cycles after start
    initial begin
        int cyc, st, mchecks;
        cyc = 0;
        st = -1;
        mchecks = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                st = -1;
            end else begin
                if (dut.u_mm.done && st >= 0 && mchecks < 4) begin
                    check("mm_latency", cyc - st, W + 1);
                    mchecks++;
                    st = -1;
                end
                if (dut.u_mm.start) st = cyc;
            end
        end
    end

    initial begin
        logic [W-1:0] c, d, n, e;
        int hold;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_plaint", plaint, '0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // textbook vector with 10 cycles of backpressure and an ignored second request
        start_job(32'd2790, 32'd2753, 32'd3233);
        wait_result();
        check("vec65_plaint", got_p, 32'd65);
        check("vec65_err", got_err, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cipht    = 32'd1234;
                d_key    = 32'd7;
                n_key    = 32'd3233;
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
            @(negedge clk);
            check("bp_plaint", plaint, 32'd65);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        handshake();
        repeat (5) @(negedge clk);
        check("bp_second_ignored", out_valid, 1'b0);

        run_job("c0", 32'd0, 32'd2753, 32'd3233, 32'd0, 1'b0);
        run_job("c1", 32'd1, 32'd2753, 32'd3233, 32'd1, 1'b0);

        start_job(32'd2790, 32'd0, 32'd3233);
        wait_result();
        check("d0_plaint", got_p, 32'd1);
        check("d0_latency", lat, 2);
        handshake();

        // abort mid-squaring
        start_job(32'd2790, 32'd2753, 32'd3233);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_plaint", plaint, '0);
        check("abort_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_output", out_valid, 1'b0);
        run_job("after_abort", 32'd2790, 32'd2753, 32'd3233, 32'd65, 1'b0);

        for (int k = 0; k < 8; k++) begin
            n = $urandom;
            if (n < 2) n = 32'd3;
            c = $urandom % n;
            d = $urandom >> $urandom_range(0, 31);
            e = W'(ref_modexp(longint'(c), longint'(d), longint'(n)));
            start_job(c, d, n);
            wait_result();
            check("rand_plaint", got_p, e);
            check("rand_err", got_err, 1'b0);
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            check("rand_hold_plaint", plaint, e);
            handshake();
        end

`ifdef RSA_DEC_RANGE_CHK_EN
        start_job(32'd3233, 32'd2753, 32'd3233);
        wait_result();
        check("rng_c_eq_n_err", got_err, 1'b1);
        check("rng_c_eq_n_plaint", got_p, '0);
        check("rng_c_eq_n_latency", lat, 2);
        handshake();
        start_job(32'd0, 32'd5, 32'd1);
        wait_result();
        check("rng_n1_err", got_err, 1'b1);
        check("rng_n1_latency", lat, 2);
        handshake();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
RSA_DECRYPT -- requirements
Module: rsa_decrypt

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width for ciphertext, plaintext, exponent and modulus.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cipht  input  WIDTH  ciphertext c.
REQ-005 SHALL have port: d_key  input  WIDTH  private exponent d.
REQ-006 SHALL have port: n_key  input  WIDTH  modulus n.
REQ-007 SHALL have port: in_valid  input  1  cipht/d_key/n_key valid.
REQ-008 SHALL have port: in_ready  output  1  block can accept a job.
REQ-009 SHALL have port: plaint  output  WIDTH  recovered plaintext m = c^d mod n.
REQ-010 SHALL have port: out_valid  output  1  plaint valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts plaint.
REQ-012 SHALL have port: err  output  1  range error flag, qualified by out_valid.

Function
REQ-013 SHALL accept a job on the cycle with in_valid && in_ready, latching c, d and n internally; later changes to inputs do not affect the job.
REQ-014 SHALL assert in_ready only in IDLE; one job in flight, no input buffering.
REQ-015 SHALL use states IDLE, LOAD, SQR, MUL, DONE: IDLE->LOAD on accept; LOAD->SQR, or LOAD->DONE if d==0 or error; SQR->MUL if the current exponent bit is 1, else SQR->next bit; MUL->next bit; after the LSB -> DONE; DONE->IDLE on out_ready.
REQ-016 SHALL compute by left-to-right square-and-multiply: LOAD sets acc=1 and bit index = position of the MSB set in d; for each bit from there down to 0, acc=acc*acc mod n, then acc=acc*c mod n if the bit is 1.
REQ-017 SHALL start each modular multiply with a single-cycle start pulse to the sub-module and wait for its single-cycle done pulse.
REQ-018 Each modular multiply SHALL take exactly WIDTH+1 cycles from start to done, by interleaved shift-add with conditional subtraction, intermediates WIDTH+2 bits wide, no overflow for operands < n.
REQ-019 SHALL produce plaint=1 mod n when d==0 (i.e. 1 for n>=2).
REQ-020 SHALL hold out_valid, plaint and err stable in DONE until out_ready; out_valid && out_ready returns to IDLE, and in_ready rises the next cycle.
REQ-021 SHALL keep plaint=0 and err=0 whenever out_valid is low.
REQ-022 SHALL ignore in_valid while not in IDLE.

Reset
REQ-023 On reset, SHALL go to IDLE from any state, including mid-multiply, and abort the job with no output produced.
REQ-024 Reset values SHALL be: in_ready=1 after release, out_valid=0, plaint=0, err=0, internal acc/operands=0.

Configuration
REQ-025 With macro RSA_DEC_RANGE_CHK_EN defined, LOAD SHALL flag c>=n or n<2 as an error: go to DONE with plaint=0 and err=1, with out_valid asserted 2 cycles after accept.
REQ-026 Without RSA_DEC_RANGE_CHK_EN, err SHALL be tied to 0, and the result for c>=n or n<2 is undefined.

Structure
REQ-027 A shared package rsa_pkg SHALL hold the default WIDTH constant and the state enumeration typedef (IDLE, LOAD, SQR, MUL, DONE).
REQ-028 SHALL instantiate one sub-module, rsa_modmul_seq, with ports start, a, b, n, done, p; it is reused for both squaring and multiplying.

Verification
REQ-029 n=3233, d=2753, c=2790 -> plaint=65, err=0, out_valid held until out_ready.
REQ-030 n=3233, d=2753, c=0 -> plaint=0; c=1 -> plaint=1.
REQ-031 n=3233, d=0, c=2790 -> plaint=1, reached via LOAD->DONE.
REQ-032 Backpressure: out_ready held low 10 cycles after out_valid -> plaint stable, in_ready low, second in_valid ignored; in_ready rises the cycle after the handshake.
REQ-033 Reset asserted mid-SQR -> out_valid=0, plaint=0, next job (c=2790) -> 65.
REQ-034 With RSA_DEC_RANGE_CHK_EN: n=3233, c=3233 -> err=1, plaint=0, out_valid 2 cycles after accept; n=1 -> err=1.
